pmod_pattern_gen: RTL and testbench

//  Parametrised LED/PMOD pattern generator for board bring-up and demos. Drives N_CH PMOD pins
//  and the status LED from one clock, using an exact-divide tick enable instead of derived clocks.

---
 rtl/pmod_pattern_gen_pkg.sv | 18 +
 rtl/pmod_pattern_gen_tick_prescaler.sv | 46 ++++
 rtl/pmod_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_pmod_pattern_gen.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pmod_pattern_gen_pkg.sv
// Shared definitions for the PMOD/LED pattern generator.
//   mode_e      : pattern mode encoding as seen on the MODE pin
//   clog2_min1  : counter width helper that never returns 0
package pmod_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ModeBinary = 2'd0,
    ModeWalk   = 2'd1,
    ModeBreath = 2'd2,
    ModeOff    = 2'd3
  } mode_e;

  // Width needed to hold values 0..n-1; at least one bit so single-value counters stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmod_pattern_gen_tick_prescaler.sv
// Exact modulo-DIV tick-enable generator.
//   CLK_48 : clock
//   RST    : synchronous reset, active-high
//   EN     : count enable; while low the counter holds and no tick is issued
//   TICK   : registered one-cycle pulse, high in the cycle after the counter reaches DIV-1
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic CLK_48,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick_q, tick_d;

  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (EN) begin
      if (pre_q == PreMax) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge CLK_48) begin
    if (RST) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/pmod_pattern_gen.sv
// LED/PMOD pattern generator for board bring-up: binary count, bouncing walk,
// PWM breathing or off, all from one clock using a tick enable.
//   CLK_48   : board clock
//   RST      : synchronous reset, active-high, overrides everything
//   RUN      : 1 = advance, 0 = freeze all state (outputs hold, TICK low)
//   MODE     : 0 binary, 1 walk, 2 breath, 3 off; taken only on tick cycles
//   PMOD_OUT : registered pattern outputs
//   LED_A    : registered status LED, active-low
//   TICK     : registered one-cycle pulse at TICK_HZ
module pmod_pattern_gen
  import pmod_pattern_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 48_000_000,
  parameter int unsigned TICK_HZ    = 10_000,
  parameter int unsigned N_CH       = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned STEP_TICKS = 1000
) (
  input  logic            CLK_48,
  input  logic            RST,
  input  logic            RUN,
  input  logic [1:0]      MODE,
  output logic [N_CH-1:0] PMOD_OUT,
  output logic            LED_A,
  output logic            TICK
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PosW    = clog2_min1(N_CH);
  localparam int unsigned StepW   = clog2_min1(STEP_TICKS);
  localparam int unsigned HbTicks = (TICK_HZ / 2 >= 1) ? TICK_HZ / 2 : 1;
  localparam int unsigned HbW     = clog2_min1(HbTicks);

  localparam logic [PosW-1:0]  PosMax  = PosW'(N_CH - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(STEP_TICKS - 1);
  localparam logic [HbW-1:0]   HbMax   = HbW'(HbTicks - 1);
  localparam logic [PWM_W-1:0] DutyMax = '1;

  if (DIV < 2) begin : g_div_check
    $error("pmod_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (N_CH < 1 || N_CH > CNT_W) begin : g_nch_check
    $error("pmod_pattern_gen: N_CH must be in 1..CNT_W");
  end
  if (STEP_TICKS < 1) begin : g_step_check
    $error("pmod_pattern_gen: STEP_TICKS must be at least 1");
  end

  // A tick only acts if the block is running in the cycle that consumes it.
  logic tick_en;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .CLK_48(CLK_48),
    .RST   (RST),
    .EN    (RUN),
    .TICK  (TICK)
  );

  assign tick_en = TICK & RUN;

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] pwm_ctr_q, pwm_ctr_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             duty_down_q, duty_down_d;
  logic [StepW-1:0] step_ctr_q, step_ctr_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic             dir_down_q, dir_down_d;
  logic [HbW-1:0]   hb_ctr_q, hb_ctr_d;
  logic             hb_q, hb_d;
  logic [N_CH-1:0]  pmod_q, pmod_d;
  logic             led_q, led_d;
  logic             pwm_on;

  assign pwm_on = (pwm_ctr_q < duty_q);

  always_comb begin
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    pwm_ctr_d   = pwm_ctr_q;
    duty_d      = duty_q;
    duty_down_d = duty_down_q;
    step_ctr_d  = step_ctr_q;
    pos_d       = pos_q;
    dir_down_d  = dir_down_q;
    hb_ctr_d    = hb_ctr_q;
    hb_d        = hb_q;
    pmod_d      = pmod_q;
    led_d       = led_q;

    if (RUN) begin
      cnt_d     = cnt_q + CNT_W'(1);
      pwm_ctr_d = pwm_ctr_q + PWM_W'(1);

      // Outputs reflect the state held before this edge.
      unique case (mode_q)
        ModeBinary: pmod_d = cnt_q[CNT_W-1 -: N_CH];
        ModeWalk:   pmod_d = N_CH'(1) << pos_q;
        ModeBreath: pmod_d = {N_CH{pwm_on}};
        ModeOff:    pmod_d = '0;
        default:    pmod_d = '0;
      endcase
      led_d = (mode_q == ModeBreath) ? ~pwm_on : ~hb_q;
    end

    if (tick_en) begin
      // Heartbeat runs through mode changes; only reset clears it.
      if (hb_ctr_q == HbMax) begin
        hb_ctr_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_ctr_d = hb_ctr_q + HbW'(1);
      end

      mode_d = mode_e'(MODE);
      if (mode_d != mode_q) begin
        pos_d       = '0;
        dir_down_d  = 1'b0;
        duty_d      = '0;
        duty_down_d = 1'b0;
        step_ctr_d  = '0;
      end else begin
        // Triangle duty: each end value lasts exactly one tick before reversing.
        if (!duty_down_q) begin
          if (duty_q == DutyMax) begin
            duty_down_d = 1'b1;
            duty_d      = duty_q - PWM_W'(1);
          end else begin
            duty_d = duty_q + PWM_W'(1);
          end
        end else begin
          if (duty_q == '0) begin
            duty_down_d = 1'b0;
            duty_d      = duty_q + PWM_W'(1);
          end else begin
            duty_d = duty_q - PWM_W'(1);
          end
        end

        if (step_ctr_q == StepMax) begin
          step_ctr_d = '0;
          // Bounce without repeating the end position; a single channel never moves.
          if (!dir_down_q) begin
            if (pos_q == PosMax) begin
              dir_down_d = 1'b1;
              if (N_CH > 1) pos_d = pos_q - PosW'(1);
            end else begin
              pos_d = pos_q + PosW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_down_d = 1'b0;
              if (N_CH > 1) pos_d = pos_q + PosW'(1);
            end else begin
              pos_d = pos_q - PosW'(1);
            end
          end
        end else begin
          step_ctr_d = step_ctr_q + StepW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_48) begin
    if (RST) begin
      mode_q      <= ModeBinary;
      cnt_q       <= '0;
      pwm_ctr_q   <= '0;
      duty_q      <= '0;
      duty_down_q <= 1'b0;
      step_ctr_q  <= '0;
      pos_q       <= '0;
      dir_down_q  <= 1'b0;
      hb_ctr_q    <= '0;
      hb_q        <= 1'b0;
      pmod_q      <= '0;
      led_q       <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      pwm_ctr_q   <= pwm_ctr_d;
      duty_q      <= duty_d;
      duty_down_q <= duty_down_d;
      step_ctr_q  <= step_ctr_d;
      pos_q       <= pos_d;
      dir_down_q  <= dir_down_d;
      hb_ctr_q    <= hb_ctr_d;
      hb_q        <= hb_d;
      pmod_q      <= pmod_d;
      led_q       <= led_d;
    end
  end

  assign PMOD_OUT = pmod_q;
  assign LED_A    = led_q;

endmodule

// File: tb/tb_pmod_pattern_gen.sv
module tb_pmod_pattern_gen;

  localparam int unsigned NCh  = 4;
  localparam int          Div  = 10;
  localparam int          Step = 2;
  localparam int          DMax = 7;   // 2^PWM_W - 1
  localparam int          Hb   = 5;   // TICK_HZ / 2

  logic           clk = 1'b0;
  logic           rst, run;
  logic [1:0]     mode;
  logic [NCh-1:0] pmod;
  logic           led, tick;

  always #5 clk = ~clk;

  pmod_pattern_gen #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .N_CH      (NCh),
    .CNT_W     (8),
    .PWM_W     (3),
    .STEP_TICKS(Step)
  ) dut (
    .CLK_48  (clk),
    .RST     (rst),
    .RUN     (run),
    .MODE    (mode),
    .PMOD_OUT(pmod),
    .LED_A   (led),
    .TICK    (tick)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: everything is derived from how many running cycles have
  // elapsed since reset and how many ticks since the current mode was entered.
  int             m_run;    // running cycles since reset
  int             m_since;  // ticks consumed since mode entry
  int             m_hb;     // ticks consumed since reset
  int             m_mode;
  logic           e_tick;
  logic [NCh-1:0] e_pmod;
  logic           e_led;

  function automatic int tri_wave(input int t, input int peak);
    int r;
    if (peak == 0) return 0;
    r = t % (2 * peak);
    return (r <= peak) ? r : 2 * peak - r;
  endfunction

  task automatic model_edge();
    int duty, pos;
    bit pwm_on;
    if (rst) begin
      m_run = 0; m_since = 0; m_hb = 0; m_mode = 0;
      e_tick = 1'b0; e_pmod = '0; e_led = 1'b1;
    end else if (run) begin
      duty   = tri_wave(m_since, DMax);
      pos    = tri_wave(m_since / Step, NCh - 1);
      pwm_on = (m_run % (DMax + 1)) < duty;
      case (m_mode)
        0:       e_pmod = NCh'((m_run % 256) / 16);
        1:       e_pmod = NCh'(1 << pos);
        2:       e_pmod = {NCh{pwm_on}};
        default: e_pmod = '0;
      endcase
      e_led = (m_mode == 2) ? !pwm_on : !(((m_hb / Hb) % 2) == 1);
      if (e_tick) begin
        m_hb++;
        if (int'(mode) != m_mode) begin
          m_mode  = int'(mode);
          m_since = 0;
        end else begin
          m_since++;
        end
      end
      e_tick = (m_run % Div) == Div - 1;
      m_run++;
    end else begin
      e_tick = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic ru, input logic [1:0] m);
    rst  = r;
    run  = ru;
    mode = m;
    @(posedge clk);
    model_edge();
    #1;
    check("pmod", 8'(pmod), 8'(e_pmod));
    check("led", 8'(led), 8'(e_led));
    check("tick", 8'(tick), 8'(e_tick));
  endtask

  initial begin
    int          k;
    int          len;
    logic [1:0]  m;
    logic        ru;

    // Reset, then binary count across a full counter wrap.
    repeat (3) cyc(1'b1, 1'b0, 2'd0);
    repeat (300) cyc(1'b0, 1'b1, 2'd0);

    // Walk with a 50-cycle freeze at a random point.
    k = $urandom_range(30, 150);
    repeat (k) cyc(1'b0, 1'b1, 2'd1);
    repeat (50) cyc(1'b0, 1'b0, 2'd1);
    repeat (200) cyc(1'b0, 1'b1, 2'd1);

    // Brief excursion to OFF and back to WALK between ticks.
    k = $urandom_range(3, 25);
    repeat (k) cyc(1'b0, 1'b1, 2'd3);
    repeat (60) cyc(1'b0, 1'b1, 2'd1);

    // Breathing over more than one full triangle, then reset mid-pattern.
    repeat (200) cyc(1'b0, 1'b1, 2'd2);
    repeat (2) cyc(1'b1, 1'b1, 2'd2);
    repeat (200) cyc(1'b0, 1'b1, 2'd2);

    // Random modes with occasional RUN drops and rare resets.
    for (int i = 0; i < 60; i++) begin
      m   = 2'($urandom_range(0, 3));
      len = $urandom_range(5, 60);
      for (int j = 0; j < len; j++) begin
        ru = ($urandom_range(0, 9) != 0);
        cyc(($urandom_range(0, 399) == 0), ru, m);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
